slave_port: RTL and testbench
=============================

Name: slave_port

Overview:
- Serial-to-parallel front end of a bus slave. It sits directly downstream of master_port on the serial bus (mwdata/mmode/mvalid in, srdata/svalid out).
- It deserialises the address and write data, drives a synchronous local memory port, and serialises read data back to the master.
- It also signals sready when it can accept a new frame.

Parameters:
- ADDR_WIDTH, 12, slave-local address bits received per frame.
- DATA_WIDTH, 8, data bits per transfer.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- swdata  in  1  serial write stream from master (address bits, then data bits).
- smode  in  1  0 = read, 1 = write; sampled on the first valid bit of a frame.
- mvalid  in  1  master bit-valid qualifier for swdata.
- srdata  out  1  serial read data to master.
- svalid  out  1  read-data bit valid.
- sready  out  1  high when idle and able to accept a new frame.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wen  out  1  one-cycle write strobe.
- mem_ren  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_WIDTH  memory read data, valid exactly 1 cycle after mem_ren.

Behaviour:
- Reset: synchronous, active-high. On reset every output is 0 except sready=1; state=IDLE; bit counter=0; shift registers=0.
- Reset mid-frame aborts the transaction. No mem strobe is issued, and svalid drops the next cycle.
- Bit order is LSB first for address, write data and read data.
- A bit is consumed only on a cycle with mvalid=1. Cycles with mvalid=0 inside ADDR/WDATA stall the frame: counter and registers hold, no timeout.
- IDLE:
  - sready=1.
  - On mvalid=1: latch smode, shift swdata in as addr[0], counter=1, sready->0, go to ADDR.
  - If ADDR_WIDTH==1, go straight to the next phase.
- ADDR: shift one bit per valid cycle. When the ADDR_WIDTH-th bit is taken, reset the counter and go to:
  - WDATA if mode=1;
  - RDREQ if mode=0.
- WDATA: shift DATA_WIDTH bits. On the last bit go to WR.
- WR (1 cycle): mem_wen=1, mem_addr/mem_wdata stable; then go to IDLE.
  - Write latency: mem_wen is asserted the cycle after the last data bit is sampled.
  - sready returns to 1 the cycle after mem_wen.
- RDREQ (1 cycle): mem_ren=1; go to RDWAIT.
- RDWAIT (1 cycle): capture mem_rdata into the output shift register; go to RDATA.
- RDATA:
  - svalid=1 for exactly DATA_WIDTH consecutive cycles, srdata = rdata bit k in cycle k.
  - After the last bit, svalid=0 and go to IDLE with sready=1.
  - Read latency: the first svalid cycle is 3 cycles after the last address bit is sampled.
- mem_addr holds the last received address until the next frame completes its address phase.
- mem_wen and mem_ren are never high together; each is a single-cycle pulse.
- mvalid during WR/RDREQ/RDWAIT/RDATA is ignored: no bits are consumed and the state is not disturbed.
- The master must wait for sready.
- The counter is sized clog2(max(ADDR_WIDTH,DATA_WIDTH)+1) and saturates only through state change; no wrap inside a phase.

Decomposition:
- Shared package bus_pkg holds:
  - mode constants MODE_READ=0, MODE_WRITE=1;
  - state encoding (IDLE, ADDR, WDATA, WR, RDREQ, RDWAIT, RDATA);
  - default widths.
- One natural sub-module: slave_shift_reg, a parameterised LSB-first shift register with load/shift-in/shift-out.
  - It is instantiated for address, write data and read data.
- The FSM and counter stay in slave_port.

Test Plan:
1. Write, no stall: addr 0x5A3, data 0xC7, mvalid continuous for 20 cycles.
   - mem_wen pulses once, 1 cycle after the last bit, with mem_addr=0x5A3 and mem_wdata=0xC7.
   - sready=0 throughout, then 1 the next cycle.
2. Read: memory returns 0x3D at addr 0x0FF.
   - mem_ren pulses 1 cycle after addr bit 11.
   - svalid is high for 8 cycles starting 3 cycles after bit 11, with srdata sequence 1,0,1,1,1,1,0,0.
3. Stalled write: addr 0x001, data 0x80, mvalid deasserted for 3 cycles after address bit 4 and 2 cycles after data bit 2.
   - Same result as the unstalled case, with mem_wen delayed by exactly 5 cycles.
4. Reset mid-frame: rst=1 after 6 address bits.
   - Next cycle: sready=1, no mem strobe.
   - A following clean write of 0x7FF/0x11 completes correctly.
5. Busy ignore: pulse mvalid with swdata=1 during RDATA.
   - Read-out bits are unchanged.
   - No new frame starts until sready=1.
6. Back-to-back: write 0xABC/0x55, then read 0xABC the cycle sready rises.
   - mem_wen then mem_ren, never overlapping.
   - The read returns 0x55 serially.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: transfer modes, slave FSM states
// and default widths.
package bus_pkg;

   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 8;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      WR,
      RDREQ,
      RDWAIT,
      RDATA
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slave_shift_reg.sv
// LSB-first shift register: serial bits enter at the MSB and move toward bit 0.
// With SERIAL_OUT set, only bit 0 (the next bit to leave) is exposed.
module slave_shift_reg #(
   parameter int WIDTH      = 8,
   parameter bit SERIAL_OUT = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_load,
   input  logic [WIDTH-1:0]                     i_load_data,
   input  logic                                 i_shift,
   input  logic                                 i_bit,
   output logic [(SERIAL_OUT ? 1 : WIDTH)-1:0]  o_q
);

   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_next;

   generate
      if (WIDTH == 1) begin : g_single
         assign w_next = i_bit;
      end else begin : g_multi
         assign w_next = {i_bit, r_data[WIDTH-1:1]};
      end

      if (SERIAL_OUT) begin : g_serial
         assign o_q = r_data[0];
      end else begin : g_parallel
         assign o_q = r_data;
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_load_data;
      end else if (i_shift) begin
         r_data <= w_next;
      end
   end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave front end: deserialises address/write data, drives a
// synchronous memory port and serialises read data back to the master.
module slave_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  swdata,
   input  logic                  smode,
   input  logic                  mvalid,
   output logic                  srdata,
   output logic                  svalid,
   output logic                  sready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wen,
   output logic                  mem_ren,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(max2(ADDR_WIDTH, DATA_WIDTH) + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  r_mode;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  w_addr_last;
   logic                  w_addr_shift;
   logic [ADDR_WIDTH-1:0] w_addr_full;
   logic [DATA_WIDTH-1:0] w_wdata_q;
   logic                  w_rd_lsb;

   assign w_addr_shift = mvalid && (r_state == IDLE || r_state == ADDR);

   // The address register holds all but the final bit; the final bit is merged
   // on the fly so mem_addr is valid in the very next cycle.
   generate
      if (ADDR_WIDTH > 1) begin : g_addr_sr
         logic [ADDR_WIDTH-2:0] w_addr_q;

         slave_shift_reg #(.WIDTH(ADDR_WIDTH - 1), .SERIAL_OUT(1'b0)) u_addr_sr (
            .clk         (clk),
            .rst         (rst),
            .i_load      (1'b0),
            .i_load_data ('0),
            .i_shift     (w_addr_shift),
            .i_bit       (swdata),
            .o_q         (w_addr_q)
         );

         assign w_addr_full = {swdata, w_addr_q};
      end else begin : g_addr_bit
         assign w_addr_full = swdata;
      end
   endgenerate

   slave_shift_reg #(.WIDTH(DATA_WIDTH), .SERIAL_OUT(1'b0)) u_wdata_sr (
      .clk         (clk),
      .rst         (rst),
      .i_load      (1'b0),
      .i_load_data ('0),
      .i_shift     (mvalid && r_state == WDATA),
      .i_bit       (swdata),
      .o_q         (w_wdata_q)
   );

   slave_shift_reg #(.WIDTH(DATA_WIDTH), .SERIAL_OUT(1'b1)) u_rdata_sr (
      .clk         (clk),
      .rst         (rst),
      .i_load      (r_state == RDWAIT),
      .i_load_data (mem_rdata),
      .i_shift     (r_state == RDATA),
      .i_bit       (1'b0),
      .o_q         (w_rd_lsb)
   );

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_last = 1'b0;
      case (r_state)
         IDLE: begin
            if (mvalid) begin
               if (ADDR_WIDTH == 1) begin
                  w_addr_last = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = (smode == MODE_WRITE) ? WDATA : RDREQ;
               end else begin
                  w_cnt_nxt   = CNT_ONE;
                  w_state_nxt = ADDR;
               end
            end
         end
         ADDR: begin
            if (mvalid) begin
               if (r_cnt == ADDR_LAST) begin
                  w_addr_last = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = (r_mode == MODE_WRITE) ? WDATA : RDREQ;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
         end
         WDATA: begin
            if (mvalid) begin
               if (r_cnt == DATA_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = WR;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
         end
         WR:     w_state_nxt = IDLE;
         RDREQ:  w_state_nxt = RDWAIT;
         RDWAIT: w_state_nxt = RDATA;
         RDATA: begin
            if (r_cnt == DATA_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: reset is synchronous, so it is sampled only on the clock edge and
   // a mid-frame assertion simply returns the FSM to IDLE on the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_mode     <= MODE_READ;
         r_mem_addr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == IDLE && mvalid) begin
            r_mode <= smode;
         end
         if (w_addr_last) begin
            r_mem_addr <= w_addr_full;
         end
      end
   end

   assign sready    = (r_state == IDLE);
   assign svalid    = (r_state == RDATA);
   assign srdata    = svalid & w_rd_lsb;
   assign mem_wen   = (r_state == WR);
   assign mem_ren   = (r_state == RDREQ);
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = w_wdata_q;

endmodule

// File: tb/tb_slave_port.sv
// Self-checking bench for slave_port: directed scenarios plus randomized
// frames checked against an array-level memory model.
module tb_slave_port;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          swdata = 1'b0;
   logic          smode = 1'b0;
   logic          mvalid = 1'b0;
   logic          srdata;
   logic          svalid;
   logic          sready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wen;
   logic          mem_ren;
   logic [DW-1:0] mem_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;
   int wen_cnt = 0;
   int ren_cnt = 0;
   int overlap_cnt = 0;

   // dev_mem is the memory the DUT talks to; ref_mem is the expected content
   // built only from the frames the bench sends.
   logic [DW-1:0] dev_mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .swdata    (swdata),
      .smode     (smode),
      .mvalid    (mvalid),
      .srdata    (srdata),
      .svalid    (svalid),
      .sready    (sready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wen) begin
         dev_mem[mem_addr] <= mem_wdata;
         wen_cnt++;
      end
      if (mem_ren) begin
         mem_rdata <= dev_mem[mem_addr];
         ren_cnt++;
      end
      if (mem_wen && mem_ren) overlap_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one frame; only the first bit carries the real mode. Optional
   // stalls of a_len/d_len idle cycles follow address bit a_at / data bit d_at.
   task automatic send_frame(input logic mode, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input int a_at,
                             input int a_len, input int d_at, input int d_len,
                             output int n_cyc);
      int busy_bad;
      busy_bad = 0;
      n_cyc = 0;
      for (int i = 0; i < AW; i++) begin
         mvalid = 1'b1;
         swdata = addr[i];
         smode  = (i == 0) ? mode : 1'($urandom_range(0, 1));
         tick(); n_cyc++;
         if (sready !== 1'b0) busy_bad++;
         if (i + 1 == a_at) begin
            repeat (a_len) begin
               mvalid = 1'b0;
               swdata = 1'($urandom_range(0, 1));
               tick(); n_cyc++;
               if (sready !== 1'b0) busy_bad++;
            end
         end
      end
      if (mode) begin
         for (int i = 0; i < DW; i++) begin
            mvalid = 1'b1;
            swdata = data[i];
            smode  = 1'($urandom_range(0, 1));
            tick(); n_cyc++;
            if (sready !== 1'b0) busy_bad++;
            if (i + 1 == d_at) begin
               repeat (d_len) begin
                  mvalid = 1'b0;
                  swdata = 1'($urandom_range(0, 1));
                  tick(); n_cyc++;
                  if (sready !== 1'b0) busy_bad++;
               end
            end
         end
      end
      mvalid = 1'b0;
      swdata = 1'b0;
      n_checks++;
      if (busy_bad != 0) begin
         n_errors++;
         $display("FAIL frame_sready_busy: sready high in %0d frame cycles, required 0", busy_bad);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int a_at, input int a_len, input int d_at,
                           input int d_len, output int n_cyc);
      int wen_snap;
      wen_snap = wen_cnt;
      send_frame(1'b1, addr, data, a_at, a_len, d_at, d_len, n_cyc);
      n_checks++;
      if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== addr || mem_wdata !== data) begin
         n_errors++;
         $display("FAIL write_strobe: wen=%b ren=%b addr=%h wdata=%h, required wen=1 ren=0 addr=%h wdata=%h",
                  mem_wen, mem_ren, mem_addr, mem_wdata, addr, data);
      end
      ref_mem[addr] = data;
      tick();
      n_checks++;
      if (mem_wen !== 1'b0 || sready !== 1'b1 || wen_cnt != wen_snap + 1) begin
         n_errors++;
         $display("FAIL write_done: wen=%b sready=%b pulses=%0d, required wen=0 sready=1 pulses=1",
                  mem_wen, sready, wen_cnt - wen_snap);
      end
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic busy_pulse,
                          input int a_at, input int a_len);
      logic [DW-1:0] expected;
      logic [DW-1:0] got;
      int            bad_valid;
      int            n_cyc;
      expected  = ref_mem[addr];
      got       = '0;
      bad_valid = 0;
      send_frame(1'b0, addr, '0, a_at, a_len, 0, 0, n_cyc);
      n_checks++;
      if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== addr || svalid !== 1'b0) begin
         n_errors++;
         $display("FAIL read_strobe: ren=%b wen=%b addr=%h svalid=%b, required ren=1 wen=0 addr=%h svalid=0",
                  mem_ren, mem_wen, mem_addr, svalid, addr);
      end
      tick();
      n_checks++;
      if (mem_ren !== 1'b0 || svalid !== 1'b0) begin
         n_errors++;
         $display("FAIL read_wait: ren=%b svalid=%b, required 0 0", mem_ren, svalid);
      end
      tick();
      for (int k = 0; k < DW; k++) begin
         if (busy_pulse && k >= 2 && k <= 4) begin
            mvalid = 1'b1;
            swdata = 1'b1;
            smode  = 1'b1;
         end else begin
            mvalid = 1'b0;
            swdata = 1'b0;
         end
         if (svalid !== 1'b1) bad_valid++;
         got[k] = srdata;
         tick();
      end
      mvalid = 1'b0;
      swdata = 1'b0;
      n_checks++;
      if (bad_valid != 0 || got !== expected) begin
         n_errors++;
         $display("FAIL read_data addr %h: got %h with %0d svalid gaps, required %h with 0 gaps",
                  addr, got, bad_valid, expected);
      end
      n_checks++;
      if (svalid !== 1'b0 || sready !== 1'b1 || mem_addr !== addr) begin
         n_errors++;
         $display("FAIL read_end: svalid=%b sready=%b addr=%h, required 0 1 %h",
                  svalid, sready, mem_addr, addr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (sready !== 1'b1 || svalid !== 1'b0 || srdata !== 1'b0 || mem_wen !== 1'b0 ||
          mem_ren !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: sready=%b svalid=%b srdata=%b wen=%b ren=%b addr=%h wdata=%h, required 1 0 0 0 0 000 00",
                  sready, svalid, srdata, mem_wen, mem_ren, mem_addr, mem_wdata);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (sready !== 1'b1 || mem_wen !== 1'b0 || mem_ren !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle: sready=%b wen=%b ren=%b, required 1 0 0", sready, mem_wen, mem_ren);
      end
   endtask

   task automatic test_write_nostall();
      int n_cyc;
      do_write(12'h5A3, 8'hC7, 0, 0, 0, 0, n_cyc);
      n_checks++;
      if (n_cyc != AW + DW) begin
         n_errors++;
         $display("FAIL write_latency: %0d cycles to strobe, required %0d", n_cyc, AW + DW);
      end
   endtask

   task automatic test_read();
      dev_mem[12'h0FF] = 8'h3D;
      ref_mem[12'h0FF] = 8'h3D;
      do_read(12'h0FF, 1'b0, 0, 0);
   endtask

   task automatic test_stalled_write();
      int n_cyc;
      do_write(12'h001, 8'h80, 4, 3, 2, 2, n_cyc);
      n_checks++;
      if (n_cyc != AW + DW + 5) begin
         n_errors++;
         $display("FAIL stall_latency: %0d cycles to strobe, required %0d", n_cyc, AW + DW + 5);
      end
      do_read(12'h001, 1'b0, 0, 0);
   endtask

   task automatic test_reset_midframe();
      int           wen_snap;
      int           ren_snap;
      int           n_cyc;
      logic [AW-1:0] part;
      part     = 12'h2B6;
      wen_snap = wen_cnt;
      ren_snap = ren_cnt;
      for (int i = 0; i < 6; i++) begin
         mvalid = 1'b1;
         swdata = part[i];
         smode  = (i == 0) ? 1'b1 : 1'b0;
         tick();
      end
      mvalid = 1'b0;
      rst    = 1'b1;
      tick();
      n_checks++;
      if (sready !== 1'b1 || mem_wen !== 1'b0 || mem_ren !== 1'b0 || svalid !== 1'b0) begin
         n_errors++;
         $display("FAIL midframe_reset: sready=%b wen=%b ren=%b svalid=%b, required 1 0 0 0",
                  sready, mem_wen, mem_ren, svalid);
      end
      rst = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (wen_cnt != wen_snap || ren_cnt != ren_snap || sready !== 1'b1) begin
         n_errors++;
         $display("FAIL midframe_no_strobe: wen pulses=%0d ren pulses=%0d sready=%b, required 0 0 1",
                  wen_cnt - wen_snap, ren_cnt - ren_snap, sready);
      end
      do_write(12'h7FF, 8'h11, 0, 0, 0, 0, n_cyc);
      do_read(12'h7FF, 1'b0, 0, 0);
   endtask

   task automatic test_busy_ignore();
      int n_cyc;
      int wen_snap;
      do_write(12'h2C4, 8'hA6, 0, 0, 0, 0, n_cyc);
      wen_snap = wen_cnt;
      do_read(12'h2C4, 1'b1, 0, 0);
      repeat (2) tick();
      n_checks++;
      if (sready !== 1'b1 || wen_cnt != wen_snap || mem_addr !== 12'h2C4) begin
         n_errors++;
         $display("FAIL busy_ignore: sready=%b wen pulses=%0d addr=%h, required 1 0 2c4",
                  sready, wen_cnt - wen_snap, mem_addr);
      end
   endtask

   task automatic test_back_to_back();
      int n_cyc;
      int ovl_snap;
      ovl_snap = overlap_cnt;
      do_write(12'hABC, 8'h55, 0, 0, 0, 0, n_cyc);
      do_read(12'hABC, 1'b0, 0, 0);
      n_checks++;
      if (overlap_cnt != ovl_snap) begin
         n_errors++;
         $display("FAIL b2b_overlap: %0d overlapping strobe cycles, required 0", overlap_cnt - ovl_snap);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] pool [0:5];
      int            n_cyc;
      int            a_at;
      int            a_len;
      int            d_at;
      int            d_len;
      logic [AW-1:0] addr;
      for (int i = 0; i < 6; i++) pool[i] = AW'($urandom);
      for (int n = 0; n < 30; n++) begin
         addr  = pool[$urandom_range(0, 5)];
         a_at  = $urandom_range(1, AW - 1);
         a_len = $urandom_range(0, 3);
         d_at  = $urandom_range(1, DW - 1);
         d_len = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            do_write(addr, DW'($urandom), a_at, a_len, d_at, d_len, n_cyc);
            n_checks++;
            if (n_cyc != AW + DW + a_len + d_len) begin
               n_errors++;
               $display("FAIL random_write_latency: %0d cycles, required %0d",
                        n_cyc, AW + DW + a_len + d_len);
            end
         end else begin
            do_read(addr, 1'($urandom_range(0, 1)), a_at, a_len);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         dev_mem[i] = DW'($urandom);
         ref_mem[i] = dev_mem[i];
      end
      test_reset();
      test_write_nostall();
      test_read();
      test_stalled_write();
      test_reset_midframe();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      n_checks++;
      if (overlap_cnt != 0) begin
         n_errors++;
         $display("FAIL strobe_overlap_total: %0d cycles with wen and ren high, required 0", overlap_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
